cp0_unit: RTL and testbench
===========================

// Module: cp0_unit
// PURPOSE
//   Coprocessor-0 exception/interrupt responder for the 5-stage MIPS pipeline.
//   Consumes the exception code, branch-delay flag and PC that travel down from
//   the fetch/decode/execute stages (sampled at the macro-PC point in MEM).
//   Raises req to flush the pipeline and redirect fetch to the handler, and holds SR/Cause/EPC.
//   Serves mtc0/mfc0 accesses, and eret via EXLClr.
// PARAMETERS
//   HANDLER_ADDR  32'h0000_4180  exception entry PC that IF loads on req (exported, not driven here)
//   PRID_VALUE    32'h2024_0707  constant returned on read of reg 15 (PRId)
// PORTS
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   en         in   1   mtc0 write strobe (MEM stage)
//   CP0Add     in   5   register select: 12 SR, 13 Cause, 14 EPC, 15 PRId
//   CP0In      in   32  mtc0 write data
//   CP0Out     out  32  mfc0 read data (combinational)
//   VPC        in   32  PC of the instruction in MEM (victim PC)
//   BDIn       in   1   MEM instruction sits in a branch delay slot
//   ExcCodeIn  in   5   merged exception code of MEM instruction; 0 = none
//   HWInt      in   6   external interrupt lines [5:0]
//   EXLClr     in   1   eret in MEM: clear SR.EXL
//   EPCOut     out  32  current EPC (eret target)
//   req        out  1   take exception/interrupt this cycle (combinational)
// BEHAVIOUR
//   Fields: SR.IM=SR[15:10], SR.EXL=SR[1], SR.IE=SR[0]; Cause.BD=[31],
//     Cause.IP=[15:10], Cause.ExcCode=[6:2]; all other bits read 0.
//   Reset: SR=0, Cause=0, EPC=0 -> req=0, EPCOut=0, CP0Out=0 for regs 12-14.
//   int_req = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
//   exc_req = (ExcCodeIn != 0) & ~SR.EXL.
//   req = int_req | exc_req; interrupt has priority over exception.
//   Cause.IP <= HWInt every cycle (unless reset); no other state needed for IP.
//   Clock edge with req=1 (highest priority; same-cycle en and EXLClr ignored):
//     SR.EXL<=1; Cause.ExcCode<= int_req ? 5'd0 : ExcCodeIn; Cause.BD<=BDIn;
//     EPC <= BDIn ? VPC-32'd4 : VPC (32-bit wrap, no overflow check).
//   Else if EXLClr: SR.EXL<=0 (an en in the same cycle still applies; EXLClr wins on bit 1).
//   Else if en: CP0Add 12 -> SR <= CP0In & 32'h0000_FC03; 14 -> EPC <= CP0In;
//     13, 15 and any other address: write ignored.
//   Reads: 12 SR, 13 Cause, 14 EPC, 15 PRID_VALUE, others 0.
//     Read returns pre-edge value; no write-through forwarding.
//   EPCOut = EPC register; an mtc0 to EPC is visible to an eret on the next cycle.
//   While SR.EXL=1, neither a new interrupt nor an exception raises req (no nesting).
//     Cause.IP still tracks HWInt.
//   Reset asserted mid-handler: all state clears on that edge; req drops immediately
//     after the edge.
// TESTING
//   1. Reset, then mtc0 SR=32'h0000_0401, HWInt=6'b000001 next cycle -> req=1.
//      After the edge: EPC=VPC, Cause.ExcCode=0, SR.EXL=1.
//   2. ExcCodeIn=5'd4 (AdEL), BDIn=1, VPC=32'h0000_3008, EXL=0 -> req=1.
//      After the edge: EPC=32'h0000_3004, Cause=32'h8000_0010 (IP=0).
//   3. EXL=1, ExcCodeIn=5'd10, HWInt=6'h3F with IM all ones -> req=0;
//      Cause.IP reads 6'h3F; EPC unchanged.
//   4. Same cycle: req=1, en=1 to EPC with 32'hDEAD_BEEF -> EPC holds the exception
//      PC, not DEADBEEF; then EXLClr=1 -> SR.EXL=0 next cycle.
//   5. mtc0 Cause=32'hFFFF_FFFF and PRId=0 -> reads unchanged;
//      mtc0 SR=32'hFFFF_FFFF -> reads 32'h0000_FC03.
//   6. Assert reset with EXL=1 and EPC=32'h3010 -> next cycle SR=Cause=EPC=0,
//      req=0, CP0Out(15)=PRID_VALUE.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt responder: holds SR, Cause and EPC,
// raises req to redirect fetch, serves mtc0/mfc0 and eret (EXLClr).
// Ports:
//   clk, reset (sync, active-high)
//   en, CP0Add, CP0In  : mtc0 write strobe / register select / data
//   CP0Out             : mfc0 read data (combinational)
//   VPC, BDIn, ExcCodeIn, HWInt : MEM-stage victim info / interrupt lines
//   EXLClr             : eret, clears SR.EXL
//   EPCOut, req        : eret target / take-exception strobe
module cp0_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h2024_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_rd;
  logic        w_unused_param;

  // Handler address is consumed by IF, not here.
  assign w_unused_param = ^HANDLER_ADDR;

  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
  assign req       = w_int_req | w_exc_req;

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc, 2'd0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= '0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= HWInt;
      if (req) begin
        // Taking a trap overrides any same-cycle mtc0 or eret.
        r_exl <= 1'b1;
        r_exc <= w_int_req ? 5'd0 : ExcCodeIn;
        r_bd  <= BDIn;
        r_epc <= BDIn ? VPC - 32'd4 : VPC;
      end else begin
        if (en && CP0Add == 5'd12) begin
          r_im  <= CP0In[15:10];
          r_exl <= CP0In[1];
          r_ie  <= CP0In[0];
        end
        if (en && CP0Add == 5'd14)
          r_epc <= CP0In;
        // eret wins over a same-cycle SR write on EXL.
        if (EXLClr)
          r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (CP0Add)
      5'd12:   w_rd = w_sr;
      5'd13:   w_rd = w_cause;
      5'd14:   w_rd = r_epc;
      5'd15:   w_rd = PRID_VALUE;
      default: w_rd = '0;
    endcase
  end

  assign CP0Out = w_rd;
  assign EPCOut = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus random
// stimulus against a word-level reference model of SR/Cause/EPC.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2024_0707;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [4:0]  CP0Add = 5'd0;
  logic [31:0] CP0In = 32'd0;
  logic [31:0] CP0Out;
  logic [31:0] VPC = 32'd0;
  logic        BDIn = 1'b0;
  logic [4:0]  ExcCodeIn = 5'd0;
  logic [5:0]  HWInt = 6'd0;
  logic        EXLClr = 1'b0;
  logic [31:0] EPCOut;
  logic        req;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_sr = 32'd0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_epc = 32'd0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add),
    .CP0In(CP0In), .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .EPCOut(EPCOut), .req(req)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic m_int();
    return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || (ExcCodeIn != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check comb outputs, then advance model over the edge.
  task automatic cyc();
    logic r, ir;
    #1;
    r  = m_req();
    ir = m_int();
    chk("req", {31'd0, req}, {31'd0, r});
    chk("epcout", EPCOut, m_epc);
    chk("rd", CP0Out, m_read(CP0Add));
    @(posedge clk);
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = HWInt;
      if (r) begin
        m_sr[1] = 1'b1;
        m_cause[6:2] = ir ? 5'd0 : ExcCodeIn;
        m_cause[31] = BDIn;
        m_epc = BDIn ? VPC - 4 : VPC;
      end else begin
        if (en && CP0Add == 12) m_sr = CP0In & 32'h0000_FC03;
        if (en && CP0Add == 14) m_epc = CP0In;
        if (EXLClr) m_sr[1] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
    CP0Add = a;
    #1;
    chk(tag, CP0Out, exp);
  endtask

  task automatic idle();
    en = 0; EXLClr = 0; reset = 0; ExcCodeIn = 0; BDIn = 0;
  endtask

  initial begin
    @(negedge clk);
    // 1: reset, enable IE+IM[0], interrupt
    reset = 1; cyc();
    reset = 0;
    peek("rst_sr", 12, 0);
    peek("rst_cause", 13, 0);
    peek("rst_epc", 14, 0);
    chk("rst_req", {31'd0, req}, 0);
    en = 1; CP0Add = 12; CP0In = 32'h0000_0401; cyc();
    en = 0; HWInt = 6'b000001; VPC = 32'h0000_1000;
    #1 chk("t1_req", {31'd0, req}, 1);
    cyc();
    HWInt = 0;
    peek("t1_epc", 14, 32'h0000_1000);
    peek("t1_cause", 13, 32'h0000_0400);
    peek("t1_sr", 12, 32'h0000_0403);
    // 2: exception in delay slot
    EXLClr = 1; cyc(); EXLClr = 0;
    ExcCodeIn = 5'd4; BDIn = 1; VPC = 32'h0000_3008;
    #1 chk("t2_req", {31'd0, req}, 1);
    cyc();
    ExcCodeIn = 0; BDIn = 0;
    peek("t2_epc", 14, 32'h0000_3004);
    peek("t2_cause", 13, 32'h8000_0010);
    // 3: EXL masks everything, IP still tracks
    en = 1; CP0Add = 12; CP0In = 32'h0000_FC03; cyc(); en = 0;
    ExcCodeIn = 5'd10; HWInt = 6'h3F;
    #1 chk("t3_req", {31'd0, req}, 0);
    cyc();
    peek("t3_cause", 13, 32'h8000_FC10);
    peek("t3_epc", 14, 32'h0000_3004);
    // 4: trap beats same-cycle mtc0 EPC, then eret
    ExcCodeIn = 0; HWInt = 0; EXLClr = 1; cyc(); EXLClr = 0;
    ExcCodeIn = 5'd10; VPC = 32'h0000_2000;
    en = 1; CP0Add = 14; CP0In = 32'hDEAD_BEEF;
    #1 chk("t4_req", {31'd0, req}, 1);
    cyc();
    idle();
    peek("t4_epc", 14, 32'h0000_2000);
    EXLClr = 1; cyc(); EXLClr = 0;
    peek("t4_sr", 12, 32'h0000_FC01);
    // 5: read-only registers and SR mask
    en = 1; CP0Add = 13; CP0In = 32'hFFFF_FFFF; cyc();
    CP0Add = 15; CP0In = 0; cyc(); en = 0;
    peek("t5_cause", 13, 32'h0000_0028);
    peek("t5_prid", 15, PRID);
    en = 1; CP0Add = 12; CP0In = 32'hFFFF_FFFF; cyc(); en = 0;
    peek("t5_sr", 12, 32'h0000_FC03);
    // 6: reset mid-handler
    en = 1; CP0Add = 14; CP0In = 32'h0000_3010; cyc(); en = 0;
    peek("t6_epc", 14, 32'h0000_3010);
    HWInt = 6'h3F; ExcCodeIn = 5'd12;
    reset = 1; cyc(); reset = 0;
    HWInt = 0; ExcCodeIn = 0;
    peek("t6_sr", 12, 0);
    peek("t6_cause", 13, 0);
    peek("t6_epc", 14, 0);
    peek("t6_prid", 15, PRID);
    chk("t6_req", {31'd0, req}, 0);
    // random
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      en        = ($urandom_range(0, 2) == 0);
      CP0Add    = 5'($urandom_range(10, 16));
      CP0In     = $urandom;
      if ($urandom_range(0, 1) == 1) CP0In[1] = 1'b0;
      VPC       = $urandom;
      BDIn      = 1'($urandom);
      ExcCodeIn = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      HWInt     = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'd0;
      EXLClr    = ($urandom_range(0, 3) == 0);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
